snes_pad_reader: RTL and testbench
==================================

Name: snes_pad_reader

Overview:
- Polls one SNES controller over its 3-wire serial interface (latch, clock, data) and presents the 16 button states as a parallel register to game logic.
- Owns and sequences the controller's serial clock. It replaces the free-running divided clock with a clock-enable tick inside the clk_i domain.
- It drives the latch and clock pins directly, samples the data pin, and signals each completed frame with a 1-cycle valid pulse.

Parameters:
- HALF_DIV, 26: clk_i cycles per half-period of the controller clock. With the board clk_i this gives ~83.2 kHz. Must be >= 4.
- POLL_TICKS, 2773: half-period ticks spent idle between frames, giving ~60 Hz polling. Must be >= 1.

Ports:
- clk_i  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable_i  input  1  allows polling while high.
- snes_data_i  input  1  serial data from the controller. Asynchronous, active-low (0 = pressed).
- snes_latch_o  output  1  latch pin, active-high.
- snes_clk_o  output  1  controller clock pin. Idles high.
- buttons_o  output  16  pressed = 1. Bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12-15 unused.
- valid_o  output  1  1-cycle pulse when buttons_o updates.
- busy_o  output  1  high while a frame is in progress (state LATCH or BIT).

Behaviour:
- Clock and reset: clk_i is the clock. reset_n is asynchronous, active-low.
- Reset values:
  - snes_latch_o=0, snes_clk_o=1, buttons_o=16'h0000, valid_o=0, busy_o=0.
  - State IDLE, gap counter expired, tick counter 0, shift register 16'hFFFF.
- Tick:
  - A free-running counter counts 0..HALF_DIV-1 and asserts tick for 1 cycle at the terminal count.
  - The FSM advances only on tick cycles.
- Data input: snes_data_i passes through a 2-FF synchronizer. Only the synchronized value is sampled.
- FSM states: IDLE, LATCH, BIT.
  - IDLE: latch=0, clk=1.
    - On each tick the gap counter decrements while nonzero.
    - On a tick with enable_i=1 and gap counter 0, go to LATCH and set half-counter=0.
  - LATCH: latch=1, clk=1 for 2 ticks. On the 2nd tick go to BIT with bit index=0, phase=LOW, latch=0, clk=0.
  - BIT, phase LOW (clk=0): on tick, shift in ~data_sync at position bit index, set clk=1, phase=HIGH.
  - BIT, phase HIGH (clk=1):
    - On tick with bit index<15: increment bit index, set clk=0, phase=LOW.
    - On tick with bit index=15: go to IDLE, load the gap counter with POLL_TICKS, write the assembled word to buttons_o, and set valid_o=1 for exactly one clk_i cycle.
- Frame timing:
  - A frame is 34 ticks (2 latch + 32 clock half-periods), so exactly 16 falling and 16 rising edges on snes_clk_o.
  - Period between consecutive frame starts with enable_i held high: (34+POLL_TICKS) ticks.
- buttons_o updates atomically at frame end only. It never shows a partial frame and holds its value between frames and while disabled.
- enable_i deasserted mid-frame: the current frame completes, including its valid pulse. Then the FSM stays in IDLE.
- enable_i asserted after reset: the first frame starts on the first tick with enable_i=1, because the gap counter starts expired.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). No valid pulse is produced.
- Disconnected controller: the pulled-up line reads all 1s, so buttons_o=16'h0000 with normal valid pulses.

Decomposition:
- Shared package snes_pkg holds:
  - The state enum (IDLE, LATCH, BIT).
  - Button index constants BTN_B..BTN_R (0..11).
  - Localparam BITS_PER_FRAME=16 and LATCH_TICKS=2.
- One sub-module, snes_tick_gen:
  - Parameters: HALF_DIV.
  - Ports: clk_i, reset_n, tick_o.
  - Shared by any future second-controller instance.

Test Plan:
- Reset then enable_i=1, HALF_DIV=4, POLL_TICKS=10 -> latch high for exactly 8 clk_i cycles, then 16 low/high clk pulses of 4+4 cycles each. valid_o is 1 for one cycle at 136 cycles after the latch rise. busy_o is high for the whole frame.
- Controller model drives bits active-low for pattern 16'h0A51 -> buttons_o=16'h0A51 on the valid pulse. Check bit 0 (B) and bit 11 (R) positions explicitly.
- Data held high (no controller) -> buttons_o=16'h0000, valid pulse still produced. Consecutive frame starts are exactly 44 ticks apart.
- Drop enable_i at bit 5 of a frame -> the frame completes with correct data and one valid pulse. No further latch pulses while enable_i=0. Re-enable -> a new frame starts on the next tick once the gap has expired.
- Assert reset_n low at bit 9 -> same cycle: latch=0, clk=1, buttons_o=0, valid_o=0. After release with enable_i=1 -> a full clean frame.
- Pattern changes mid-frame (bits 0-7 from the old value, bits 8-15 from the new) -> buttons_o holds the previous frame's value until the valid pulse, then updates in a single cycle.

Source files
------------

// File: rtl/snes_pkg.sv
// rtl/snes_pkg.sv - shared state type and button constants for the SNES pad reader
package snes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        BIT   = 2'd2
    } snes_state_t;

    localparam int BITS_PER_FRAME = 16;
    localparam int LATCH_TICKS    = 2;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage

// File: rtl/snes_tick_gen.sv
// rtl/snes_tick_gen.sv - free-running half-period tick for the controller serial clock
module snes_tick_gen #(
    parameter int HALF_DIV = 26
) (
    input  logic clk_i,
    input  logic reset_n,
    output logic tick_o
);

    localparam int CNT_W = $clog2(HALF_DIV);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == CNT_W'(HALF_DIV - 1));

endmodule

// File: rtl/snes_pad_reader.sv
// rtl/snes_pad_reader.sv - polls one SNES controller and presents its 16 buttons in parallel
module snes_pad_reader
    import snes_pkg::*;
#(
    parameter int HALF_DIV   = 26,
    parameter int POLL_TICKS = 2773
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        enable_i,
    input  logic        snes_data_i,
    output logic        snes_latch_o,
    output logic        snes_clk_o,
    output logic [15:0] buttons_o,
    output logic        valid_o,
    output logic        busy_o
);

    localparam int GAP_W = $clog2(POLL_TICKS + 1);

    logic tick;

    snes_tick_gen #(
        .HALF_DIV(HALF_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .reset_n(reset_n),
        .tick_o (tick)
    );

    // Idle level of the data line is high (pulled up), so the synchronizer resets to 1.
    logic data_meta, data_sync;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_meta <= snes_data_i;
            data_sync <= data_meta;
        end
    end

    snes_state_t state_q, state_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             phase_high_q, phase_high_d;
    logic [0:0]       latch_cnt_q, latch_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d, gap_dec;
    logic [15:0]      shift_q, shift_d;
    logic [15:0]      buttons_q, buttons_d;
    logic             valid_q, valid_d;
    logic             latch_q, latch_d;
    logic             sclk_q, sclk_d;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            phase_high_q <= 1'b0;
            latch_cnt_q  <= '0;
            gap_q        <= '0;
            shift_q      <= 16'hFFFF;
            buttons_q    <= 16'h0000;
            valid_q      <= 1'b0;
            latch_q      <= 1'b0;
            sclk_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            phase_high_q <= phase_high_d;
            latch_cnt_q  <= latch_cnt_d;
            gap_q        <= gap_d;
            shift_q      <= shift_d;
            buttons_q    <= buttons_d;
            valid_q      <= valid_d;
            latch_q      <= latch_d;
            sclk_q       <= sclk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        phase_high_d = phase_high_q;
        latch_cnt_d  = latch_cnt_q;
        gap_d        = gap_q;
        shift_d      = shift_q;
        buttons_d    = buttons_q;
        valid_d      = 1'b0;
        latch_d      = latch_q;
        sclk_d       = sclk_q;
        gap_dec      = (gap_q != '0) ? gap_q - 1'b1 : '0;

        case (state_q)
            IDLE: begin
                latch_d = 1'b0;
                sclk_d  = 1'b1;
                // The tick that empties the gap also starts the frame, so exactly
                // POLL_TICKS idle ticks separate the end of one frame from the next.
                if (tick) begin
                    gap_d = gap_dec;
                    if (enable_i && gap_dec == '0) begin
                        state_d     = LATCH;
                        latch_cnt_d = '0;
                        latch_d     = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    if (latch_cnt_q == 1'(LATCH_TICKS - 1)) begin
                        state_d      = BIT;
                        bit_idx_d    = '0;
                        phase_high_d = 1'b0;
                        latch_d      = 1'b0;
                        sclk_d       = 1'b0;
                    end else begin
                        latch_cnt_d = latch_cnt_q + 1'b1;
                    end
                end
            end
            BIT: begin
                if (tick) begin
                    if (!phase_high_q) begin
                        shift_d[bit_idx_q] = ~data_sync;
                        sclk_d             = 1'b1;
                        phase_high_d       = 1'b1;
                    end else if (bit_idx_q != 4'(BITS_PER_FRAME - 1)) begin
                        bit_idx_d    = bit_idx_q + 1'b1;
                        sclk_d       = 1'b0;
                        phase_high_d = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        gap_d     = GAP_W'(POLL_TICKS);
                        buttons_d = shift_q;
                        valid_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                latch_d = 1'b0;
                sclk_d  = 1'b1;
            end
        endcase
    end

    assign snes_latch_o = latch_q;
    assign snes_clk_o   = sclk_q;
    assign buttons_o    = buttons_q;
    assign valid_o      = valid_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_snes_pad_reader.sv
// tb/tb_snes_pad_reader.sv - directed self-checking bench for snes_pad_reader
module tb_snes_pad_reader;

    logic        clk_i = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        snes_data_i;
    logic        snes_latch_o;
    logic        snes_clk_o;
    logic [15:0] buttons_o;
    logic        valid_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] pad_pattern = 16'h0A51;
    logic        pad_present = 1'b1;
    int          pad_idx = 0;

    snes_pad_reader #(
        .HALF_DIV  (4),
        .POLL_TICKS(10)
    ) dut (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .enable_i    (enable_i),
        .snes_data_i (snes_data_i),
        .snes_latch_o(snes_latch_o),
        .snes_clk_o  (snes_clk_o),
        .buttons_o   (buttons_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Controller: latch loads bit 0, each rising clock edge presents the next bit.
    always @(posedge snes_latch_o or posedge snes_clk_o) begin
        if (snes_latch_o) pad_idx = 0;
        else pad_idx = pad_idx + 1;
    end

    always_comb begin
        snes_data_i = 1'b1;
        if (pad_present && pad_idx < 16) snes_data_i = ~pad_pattern[pad_idx[3:0]];
    end

    task automatic wait_latch_rise(input int max_cycles, output int cycles, output bit ok);
        logic prev;
        ok = 1'b0;
        cycles = 0;
        prev = snes_latch_o;
        while (cycles < max_cycles && !ok) begin
            @(negedge clk_i);
            cycles++;
            if (snes_latch_o && !prev) ok = 1'b1;
            prev = snes_latch_o;
        end
    endtask

    task automatic wait_valid(input int max_cycles, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        while (cycles < max_cycles && !ok) begin
            @(negedge clk_i);
            cycles++;
            if (valid_o) ok = 1'b1;
        end
    endtask

    task automatic wait_pad_idx(input int target, input int max_cycles, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (n < max_cycles && !ok) begin
            @(negedge clk_i);
            n++;
            if (pad_idx == target) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        enable_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (snes_latch_o !== 1'b0) begin errors++; $display("FAIL reset_latch got %b want 0", snes_latch_o); end
        checks++; if (snes_clk_o !== 1'b1) begin errors++; $display("FAIL reset_clk got %b want 1", snes_clk_o); end
        checks++; if (buttons_o !== 16'h0000) begin errors++; $display("FAIL reset_buttons got %h want 0000", buttons_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    endtask

    task automatic test_frame_timing;
        int cyc, latch_hi, falls, rises, run, vcount, vidx;
        bit ok, low_bad, high_bad, busy_bad;
        logic prev_clk;
        logic [15:0] vbuttons;
        pad_present = 1'b1;
        pad_pattern = 16'h0A51;
        reset_n = 1'b1;
        enable_i = 1'b1;
        wait_latch_rise(20, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL first_latch timeout after %0d cycles want rise", cyc); end
        latch_hi = 0; falls = 0; rises = 0; run = 0; vcount = 0; vidx = -1;
        low_bad = 0; high_bad = 0; busy_bad = 0; prev_clk = 1'b1; vbuttons = '0;
        for (int c = 0; c < 150; c++) begin
            if (c > 0) @(negedge clk_i);
            latch_hi += int'(snes_latch_o);
            if ((c < 136) != busy_o) busy_bad = 1;
            if (valid_o) begin vcount++; vidx = c; vbuttons = buttons_o; end
            if (snes_clk_o != prev_clk) begin
                if (!snes_clk_o) begin
                    if (falls > 0 && run != 4) high_bad = 1;
                    falls++;
                end else begin
                    if (run != 4) low_bad = 1;
                    rises++;
                end
                run = 1;
            end else begin
                run++;
            end
            prev_clk = snes_clk_o;
        end
        checks++; if (latch_hi != 8) begin errors++; $display("FAIL latch_width got %0d want 8", latch_hi); end
        checks++; if (falls != 16) begin errors++; $display("FAIL clk_falls got %0d want 16", falls); end
        checks++; if (rises != 16) begin errors++; $display("FAIL clk_rises got %0d want 16", rises); end
        checks++; if (low_bad) begin errors++; $display("FAIL clk_low_width got bad want 4 cycles each"); end
        checks++; if (high_bad) begin errors++; $display("FAIL clk_high_width got bad want 4 cycles each"); end
        checks++; if (vidx != 136) begin errors++; $display("FAIL valid_position got %0d want 136", vidx); end
        checks++; if (vcount != 1) begin errors++; $display("FAIL valid_count got %0d want 1", vcount); end
        checks++; if (busy_bad) begin errors++; $display("FAIL busy_window got bad want high for cycles 0..135"); end
        checks++; if (vbuttons !== 16'h0A51) begin errors++; $display("FAIL frame_buttons got %h want 0a51", vbuttons); end
        checks++; if (vbuttons[0] !== 1'b1) begin errors++; $display("FAIL btn_b got %b want 1", vbuttons[0]); end
        checks++; if (vbuttons[11] !== 1'b1) begin errors++; $display("FAIL btn_r got %b want 1", vbuttons[11]); end
    endtask

    task automatic test_no_controller;
        int c1, c2, c3;
        bit ok1, ok2, ok3;
        pad_present = 1'b0;
        wait_latch_rise(200, c1, ok1);
        wait_valid(200, c2, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL nopad_valid timeout got %0d/%0d want pulse", c1, c2); end
        checks++; if (buttons_o !== 16'h0000) begin errors++; $display("FAIL nopad_buttons got %h want 0000", buttons_o); end
        wait_latch_rise(200, c3, ok3);
        checks++; if (!ok3 || (c2 + c3) != 176) begin errors++; $display("FAIL frame_period got %0d cycles want 176", c2 + c3); end
        pad_present = 1'b1;
    endtask

    task automatic test_enable_drop;
        int cyc, rises_seen, valids_seen;
        bit ok;
        logic prev;
        pad_pattern = 16'hC3A5;
        wait_latch_rise(200, cyc, ok);
        wait_pad_idx(5, 100, ok);
        enable_i = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL drop_bit5 timeout got %0d want 5", pad_idx); end
        wait_valid(200, cyc, ok);
        checks++; if (!ok || buttons_o !== 16'hC3A5) begin errors++; $display("FAIL drop_frame got %h want c3a5", buttons_o); end
        rises_seen = 0; valids_seen = 0; prev = snes_latch_o;
        repeat (300) begin
            @(negedge clk_i);
            if (snes_latch_o && !prev) rises_seen++;
            if (valid_o) valids_seen++;
            prev = snes_latch_o;
        end
        checks++; if (rises_seen != 0) begin errors++; $display("FAIL disabled_latch got %0d rises want 0", rises_seen); end
        checks++; if (valids_seen != 0) begin errors++; $display("FAIL disabled_valid got %0d pulses want 0", valids_seen); end
        checks++; if (buttons_o !== 16'hC3A5) begin errors++; $display("FAIL disabled_hold got %h want c3a5", buttons_o); end
        enable_i = 1'b1;
        wait_latch_rise(8, cyc, ok);
        checks++; if (!ok || cyc > 4) begin errors++; $display("FAIL reenable_start got %0d cycles want <=4", cyc); end
    endtask

    task automatic test_reset_mid_frame;
        int cyc;
        bit ok;
        wait_pad_idx(9, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_bit9 timeout got %0d want 9", pad_idx); end
        reset_n = 1'b0;
        #1;
        checks++; if (snes_latch_o !== 1'b0) begin errors++; $display("FAIL midreset_latch got %b want 0", snes_latch_o); end
        checks++; if (snes_clk_o !== 1'b1) begin errors++; $display("FAIL midreset_clk got %b want 1", snes_clk_o); end
        checks++; if (buttons_o !== 16'h0000) begin errors++; $display("FAIL midreset_buttons got %h want 0000", buttons_o); end
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL midreset_flags got %b%b want 00", valid_o, busy_o); end
        pad_pattern = 16'h5A0F;
        repeat (3) @(negedge clk_i);
        reset_n = 1'b1;
        wait_valid(200, cyc, ok);
        checks++; if (!ok || buttons_o !== 16'h5A0F) begin errors++; $display("FAIL postreset_frame got %h want 5a0f", buttons_o); end
    endtask

    task automatic test_pattern_change;
        int cyc, n;
        bit ok, hold_bad;
        pad_pattern = 16'hA5C3;
        wait_valid(300, cyc, ok);
        checks++; if (!ok || buttons_o !== 16'hA5C3) begin errors++; $display("FAIL old_frame got %h want a5c3", buttons_o); end
        wait_latch_rise(200, cyc, ok);
        wait_pad_idx(8, 100, ok);
        pad_pattern = 16'h3C5A;
        hold_bad = 0; ok = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk_i);
            n++;
            if (valid_o) ok = 1;
            else if (buttons_o !== 16'hA5C3) hold_bad = 1;
        end
        checks++; if (hold_bad) begin errors++; $display("FAIL hold_before_valid got change want a5c3"); end
        checks++; if (!ok || buttons_o !== 16'h3CC3) begin errors++; $display("FAIL mixed_frame got %h want 3cc3", buttons_o); end
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0 || buttons_o !== 16'h3CC3) begin errors++; $display("FAIL after_valid got %b %h want 0 3cc3", valid_o, buttons_o); end
    endtask

    initial begin
        test_reset;
        test_frame_timing;
        test_no_controller;
        test_enable_drop;
        test_reset_mid_frame;
        test_pattern_change;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
